// File: rtl/game_sequencer.sv
// Game sequencer: READY/RUN/PAUSE/LOST control, pipe scrolling, gap rotation,
// scoring and bird/pipe collision detection for a side-scrolling game.
module game_sequencer #(
    parameter int SCROLL_DIV = 131072,
    parameter int PIPE_SPAN  = 345,
    parameter int GAP_INIT   = 100,
    parameter int PIPE_X0    = 439
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        jump,
    input  logic        pause_sw,
    input  logic        restart,
    input  logic [10:0] bird_y,
    input  logic [7:0]  rand_gap,
    output logic [1:0]  state,
    output logic [9:0]  pipe_pos,
    output logic [7:0]  gap0,
    output logic [7:0]  gap1,
    output logic [3:0]  score,
    output logic [3:0]  high_score,
    output logic        bird_en
);

    typedef enum logic [1:0] {
        ST_LOST  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam int PRE_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [PRE_W-1:0] C_PRE_MAX  = PRE_W'(SCROLL_DIV - 1);
    localparam logic [9:0]       C_SPAN     = 10'(PIPE_SPAN);
    localparam logic [7:0]       C_GAP_INIT = 8'(GAP_INIT);

    // Screen geometry in pixels, signed so differences may go negative.
    localparam logic signed [12:0] C_PIPE_X0   = 13'(PIPE_X0);
    localparam logic signed [12:0] C_PIPE_W    = 13'sd50;
    localparam logic signed [12:0] C_BIRD_L    = 13'sd244;
    localparam logic signed [12:0] C_BIRD_R    = 13'sd284;
    localparam logic signed [12:0] C_SCREEN_H  = 13'sd480;
    localparam logic signed [12:0] C_BIRD_HALF = 13'sd20;
    localparam logic signed [12:0] C_GAP_LO    = 13'sd75;
    localparam logic signed [12:0] C_GAP_HI    = 13'sd215;

    state_t           r_state;
    logic             r_bird_en;
    logic [PRE_W-1:0] r_pre;
    logic [9:0]       r_pipe_pos;
    logic [7:0]       r_gap0;
    logic [7:0]       r_gap1;
    logic [3:0]       r_score;
    logic [3:0]       r_high;
    logic             r_pause_d;

    state_t           w_state_nxt;
    logic [PRE_W-1:0] w_pre_nxt;
    logic [9:0]       w_pos_nxt;
    logic [7:0]       w_gap0_nxt;
    logic [7:0]       w_gap1_nxt;
    logic [3:0]       w_score_nxt;
    logic [3:0]       w_high_nxt;

    logic               w_pause_edge;
    logic               w_tick;
    logic signed [12:0] w_pipe_left;
    logic signed [12:0] w_pipe_right;
    logic signed [12:0] w_bird_top;
    logic signed [12:0] w_gap0_s;
    logic               w_overlap;
    logic               w_vhit;
    logic               w_collision;

    assign w_pause_edge = pause_sw & ~r_pause_d;
    assign w_tick       = (r_state == ST_RUN) && (r_pre == C_PRE_MAX);

    assign w_pipe_left  = C_PIPE_X0 - $signed({3'b000, r_pipe_pos});
    assign w_pipe_right = w_pipe_left + C_PIPE_W;
    assign w_bird_top   = C_SCREEN_H - $signed({2'b00, bird_y});
    assign w_gap0_s     = $signed({5'b00000, r_gap0});
    assign w_overlap    = (C_BIRD_R > w_pipe_left) && (C_BIRD_L < w_pipe_right);
    assign w_vhit       = (w_bird_top - C_BIRD_HALF < w_gap0_s + C_GAP_LO) ||
                          (w_bird_top + C_BIRD_HALF > w_gap0_s + C_GAP_HI);
    assign w_collision  = (w_overlap && w_vhit) || (bird_y == 11'd0);

    // NOTE: clocked blocks use non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would make results depend on block order.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= ST_READY;
            r_bird_en <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bird_en <= (w_state_nxt == ST_RUN);
        end
    end

    // NOTE: each combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_READY: if (jump) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_collision)       w_state_nxt = ST_LOST;
                else if (w_pause_edge) w_state_nxt = ST_PAUSE;
            end
            ST_PAUSE: if (w_pause_edge) w_state_nxt = ST_RUN;
            ST_LOST:  if (restart) w_state_nxt = ST_READY;
        endcase
    end

    always_comb begin
        w_pre_nxt   = r_pre;
        w_pos_nxt   = r_pipe_pos;
        w_gap0_nxt  = r_gap0;
        w_gap1_nxt  = r_gap1;
        w_score_nxt = r_score;
        w_high_nxt  = (r_score > r_high) ? r_score : r_high;
        unique case (r_state)
            ST_READY: begin
                w_pre_nxt   = '0;
                w_pos_nxt   = '0;
                w_score_nxt = '0;
                w_gap0_nxt  = C_GAP_INIT;
            end
            ST_RUN: begin
                // A collision freezes everything so the losing frame stays on screen.
                if (!w_collision) begin
                    if (w_tick) begin
                        w_pre_nxt = '0;
                        if (r_pipe_pos == C_SPAN) begin
                            w_pos_nxt   = '0;
                            w_gap0_nxt  = r_gap1;
                            w_gap1_nxt  = rand_gap;
                            w_score_nxt = (r_score == 4'd15) ? r_score : r_score + 4'd1;
                        end else begin
                            w_pos_nxt = r_pipe_pos + 10'd1;
                        end
                    end else begin
                        w_pre_nxt = r_pre + PRE_W'(1);
                    end
                end
            end
            ST_LOST: begin
                if (restart) begin
                    w_pre_nxt   = '0;
                    w_pos_nxt   = '0;
                    w_score_nxt = '0;
                    w_gap0_nxt  = C_GAP_INIT;
                end
            end
            ST_PAUSE: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_pre      <= '0;
            r_pipe_pos <= '0;
            r_gap0     <= C_GAP_INIT;
            r_gap1     <= '0;
            r_score    <= '0;
            r_high     <= '0;
            r_pause_d  <= 1'b0;
        end else begin
            r_pre      <= w_pre_nxt;
            r_pipe_pos <= w_pos_nxt;
            r_gap0     <= w_gap0_nxt;
            r_gap1     <= w_gap1_nxt;
            r_score    <= w_score_nxt;
            r_high     <= w_high_nxt;
            r_pause_d  <= pause_sw;
        end
    end

    assign state      = r_state;
    assign pipe_pos   = r_pipe_pos;
    assign gap0       = r_gap0;
    assign gap1       = r_gap1;
    assign score      = r_score;
    assign high_score = r_high;
    assign bird_en    = r_bird_en;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios with literal expectations plus
// randomized play, both compared every cycle against a behavioural model.
module tb_game_sequencer;

    localparam int SD      = 4;
    localparam int SPAN    = 3;
    localparam int GINIT   = 100;
    localparam int X0_MAIN = 439;
    localparam int X0_HIT  = 280;

    logic        clk = 1'b0;
    logic        clr;
    logic        jump;
    logic        pause_sw;
    logic        restart;
    logic [10:0] bird_y;
    logic [7:0]  rand_gap;

    logic [1:0] d_state, h_state;
    logic [9:0] d_pos, h_pos;
    logic [7:0] d_g0, h_g0, d_g1, h_g1;
    logic [3:0] d_sc, h_sc, d_hi, h_hi;
    logic       d_en, h_en;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    game_sequencer #(.SCROLL_DIV(SD), .PIPE_SPAN(SPAN), .GAP_INIT(GINIT), .PIPE_X0(X0_MAIN)) u_dut (
        .clk(clk), .clr(clr), .jump(jump), .pause_sw(pause_sw), .restart(restart),
        .bird_y(bird_y), .rand_gap(rand_gap), .state(d_state), .pipe_pos(d_pos),
        .gap0(d_g0), .gap1(d_g1), .score(d_sc), .high_score(d_hi), .bird_en(d_en)
    );

    // Pipe moved into the bird's column so the gap test can actually collide.
    game_sequencer #(.SCROLL_DIV(SD), .PIPE_SPAN(SPAN), .GAP_INIT(GINIT), .PIPE_X0(X0_HIT)) u_hit (
        .clk(clk), .clr(clr), .jump(jump), .pause_sw(pause_sw), .restart(restart),
        .bird_y(bird_y), .rand_gap(rand_gap), .state(h_state), .pipe_pos(h_pos),
        .gap0(h_g0), .gap1(h_g1), .score(h_sc), .high_score(h_hi), .bird_en(h_en)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game state as the rules describe it: 0 lost, 1 ready, 2 running, 3 paused.
    typedef struct {
        int st, pre, pos, g0, g1, sc, hi, pd;
    } mdl_t;

    function automatic mdl_t model_next(input mdl_t m, input int x0);
        mdl_t n;
        bit   pedge, hit;
        int   left, top;
        n     = m;
        pedge = pause_sw && (m.pd == 0);
        left  = x0 - m.pos;
        top   = 480 - int'(bird_y);
        hit   = (bird_y == 0) ||
                ((left < 284) && (left + 50 > 244) &&
                 ((top - 20 < m.g0 + 75) || (top + 20 > m.g0 + 215)));
        n.pd = int'(pause_sw);
        if (m.sc > m.hi) n.hi = m.sc;
        if (clr) begin
            n = '{st: 1, pre: 0, pos: 0, g0: GINIT, g1: 0, sc: 0, hi: 0, pd: 0};
            return n;
        end
        case (m.st)
            1: begin
                n.pre = 0; n.pos = 0; n.sc = 0; n.g0 = GINIT;
                if (jump) n.st = 2;
            end
            2: begin
                if (hit) n.st = 0;
                else begin
                    if (pedge) n.st = 3;
                    n.pre = (m.pre + 1) % SD;
                    if (m.pre == SD - 1) begin
                        if (m.pos == SPAN) begin
                            n.pos = 0;
                            n.g0  = m.g1;
                            n.g1  = int'(rand_gap);
                            n.sc  = (m.sc + 1 > 15) ? 15 : m.sc + 1;
                        end else n.pos = m.pos + 1;
                    end
                end
            end
            3: if (pedge) n.st = 2;
            default: if (restart) begin
                n.st = 1; n.pre = 0; n.pos = 0; n.sc = 0; n.g0 = GINIT;
            end
        endcase
        return n;
    endfunction

    mdl_t m0, m1;
    bit   m_valid = 1'b0;

    always @(posedge clk) begin
        m0 <= model_next(m0, X0_MAIN);
        m1 <= model_next(m1, X0_HIT);
        if (clr) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("main.state",  int'(d_state), m0.st);
            check("main.pos",    int'(d_pos),   m0.pos);
            check("main.gap0",   int'(d_g0),    m0.g0);
            check("main.gap1",   int'(d_g1),    m0.g1);
            check("main.score",  int'(d_sc),    m0.sc);
            check("main.high",   int'(d_hi),    m0.hi);
            check("main.bird_en", int'(d_en),   int'(m0.st == 2));
            check("hit.state",   int'(h_state), m1.st);
            check("hit.pos",     int'(h_pos),   m1.pos);
            check("hit.gap0",    int'(h_g0),    m1.g0);
            check("hit.gap1",    int'(h_g1),    m1.g1);
            check("hit.score",   int'(h_sc),    m1.sc);
            check("hit.high",    int'(h_hi),    m1.hi);
            check("hit.bird_en", int'(h_en),    int'(m1.st == 2));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1; jump = 1'b0; pause_sw = 1'b0; restart = 1'b0;
        bird_y = 11'd240; rand_gap = 8'd0;
        step(2);
        clr = 1'b0;
        check("rst.state", int'(d_state), 1);
        check("rst.pos",   int'(d_pos),   0);
        check("rst.gap0",  int'(d_g0),    100);
        check("rst.gap1",  int'(d_g1),    0);
        check("rst.score", int'(d_sc),    0);
        check("rst.high",  int'(d_hi),    0);
        check("rst.en",    int'(d_en),    0);

        // Start, then a gap hit on the overlapping instance.
        jump = 1'b1;
        step(1);
        jump = 1'b0;
        check("start.state", int'(d_state), 2);
        check("start.en",    int'(d_en),    1);
        step(3);
        check("start.pos3",  int'(d_pos),   0);
        step(1);
        check("start.pos4",  int'(d_pos),   1);
        check("hit.alive",   int'(h_state), 2);
        bird_y = 11'd470;
        step(1);
        check("hit.lost",    int'(h_state), 0);
        check("hit.posheld", int'(h_pos),   1);
        check("main.nohit",  int'(d_state), 2);
        bird_y = 11'd240;

        // Wrap after the fourth tick.
        do_clr();
        rand_gap = 8'h37;
        jump = 1'b1;
        step(1);
        jump = 1'b0;
        step(15);
        check("wrap.pos_pre", int'(d_pos), 3);
        step(1);
        check("wrap.pos",   int'(d_pos), 0);
        check("wrap.gap0",  int'(d_g0),  0);
        check("wrap.gap1",  int'(d_g1),  8'h37);
        check("wrap.score", int'(d_sc),  1);
        check("wrap.hi0",   int'(d_hi),  0);
        step(1);
        check("wrap.hi1",   int'(d_hi),  1);

        // Pause for 20 cycles, resume from the frozen prescaler.
        pause_sw = 1'b1;
        step(1);
        check("pause.state", int'(d_state), 3);
        step(20);
        check("pause.pos",   int'(d_pos),   0);
        check("pause.still", int'(d_state), 3);
        pause_sw = 1'b0;
        step(1);
        pause_sw = 1'b1;
        step(1);
        check("resume.state", int'(d_state), 2);
        step(1);
        check("resume.pos0",  int'(d_pos),   0);
        step(1);
        check("resume.pos1",  int'(d_pos),   1);

        // Floor hit on a tick, then restart.
        step(3);
        bird_y = 11'd0;
        step(1);
        check("floor.state", int'(d_state), 0);
        check("floor.pos",   int'(d_pos),   1);
        check("floor.score", int'(d_sc),    1);
        bird_y = 11'd240;
        jump = 1'b1;
        step(2);
        jump = 1'b0;
        check("lost.jump",   int'(d_state), 0);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("restart.state", int'(d_state), 1);
        check("restart.score", int'(d_sc),    0);
        check("restart.pos",   int'(d_pos),   0);
        check("restart.high",  int'(d_hi),    1);
        check("restart.gap0",  int'(d_g0),    100);

        // Score saturation, then clr mid-run.
        do_clr();
        jump = 1'b1;
        step(1);
        jump = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rand_gap = 8'($urandom_range(0, 255));
            step(1);
        end
        check("sat.score", int'(d_sc), 15);
        step(80);
        check("sat.hold",  int'(d_sc), 15);
        check("sat.high",  int'(d_hi), 15);
        check("sat.run",   int'(d_state), 2);
        do_clr();
        check("clr.state", int'(d_state), 1);
        check("clr.pos",   int'(d_pos),   0);
        check("clr.gap0",  int'(d_g0),    100);
        check("clr.gap1",  int'(d_g1),    0);
        check("clr.score", int'(d_sc),    0);
        check("clr.high",  int'(d_hi),    0);
        check("clr.en",    int'(d_en),    0);

        // Randomized play.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      bird_y = 11'd0;
            else if (sel < 7)  bird_y = 11'($urandom_range(185, 285));
            else               bird_y = 11'($urandom_range(0, 2047));
            rand_gap = 8'($urandom_range(0, 255));
            jump     = ($urandom_range(0, 3) == 0);
            restart  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) pause_sw = ~pause_sw;
            clr      = ($urandom_range(0, 199) == 0);
            step(1);
        end
        clr = 1'b0;
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
